// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the shift execute stage: opcode encodings and flag bit positions.
package shift_exec_stage_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_W = 3;

endpackage

// File: rtl/shift_exec_stage_barrel.sv
// Logarithmic barrel shifter (logical and rotate) with carry-out of the last bit moved past the edge.
module BarrelShifter
  import shift_exec_stage_pkg::*;
#(
  parameter  int width = 16,
  localparam int level = $clog2(width)
) (
  input  logic [width-1:0] a,
  input  logic [level-1:0] b,
  input  shift_op_e        op,
  output logic [width-1:0] y,
  output logic             c
);

  logic [level:0][width-1:0] stg;
  logic [level-1:0]          b_m1;
  logic [level-1:0]          b_neg;

  assign stg[0] = a;

  // Level gi shifts by 2**gi when count bit gi is set.
  for (genvar gi = 0; gi < level; gi++) begin : g_lvl
    localparam int SH = 1 << gi;
    logic [width-1:0] ror_v;
    logic [width-1:0] rol_v;

    assign ror_v = {stg[gi][SH-1:0], stg[gi][width-1:SH]};
    assign rol_v = {stg[gi][width-SH-1:0], stg[gi][width-1:width-SH]};

    assign stg[gi+1] = !b[gi]         ? stg[gi]       :
                       (op == OP_SRL) ? stg[gi] >> SH :
                       (op == OP_SLL) ? stg[gi] << SH :
                       (op == OP_ROR) ? ror_v         : rol_v;
  end

  assign y = stg[level];

  // width-b wraps to the right index because the count is exactly level bits wide.
  assign b_m1  = b - level'(1);
  assign b_neg = level'(0) - b;

  always_comb begin
    c = 1'b0;
    if (b != '0) begin
      case (op)
        OP_SRL: c = a[b_m1];
        OP_SLL: c = a[b_neg];
        OP_ROR: c = y[width-1];
        OP_ROL: c = y[0];
      endcase
    end
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage valid/ready shift execute stage: S1 holds operands, S2 holds the shifted result and {n,z,c}.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter  int width = 16,
  localparam int level = $clog2(width)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [width-1:0]  a,
  input  logic [level-1:0]  b,
  input  logic [1:0]        opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [width-1:0]  y,
  output logic [FLAG_W-1:0] flags
);

  logic              s1_valid_q, s1_valid_d;
  logic [width-1:0]  s1_a_q, s1_a_d;
  logic [level-1:0]  s1_b_q, s1_b_d;
  shift_op_e         s1_op_q, s1_op_d;
  logic              s2_valid_q, s2_valid_d;
  logic [width-1:0]  y_q, y_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic              s2_drain;
  logic              s1_adv;
  logic              accept;
  logic [width-1:0]  sh_y;
  logic              sh_c;
  logic [FLAG_W-1:0] sh_flags;

  BarrelShifter #(.width(width)) u_shifter (
    .a  (s1_a_q),
    .b  (s1_b_q),
    .op (s1_op_q),
    .y  (sh_y),
    .c  (sh_c)
  );

  assign sh_flags[FLAG_N] = sh_y[width-1];
  assign sh_flags[FLAG_Z] = (sh_y == '0);
  assign sh_flags[FLAG_C] = sh_c;

  assign s2_drain = s2_valid_q && out_ready;
  assign s1_adv   = s1_valid_q && (!s2_valid_q || s2_drain);
  assign in_ready = !flush && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    flags_d    = flags_q;

    // Flush wins over any accept or advance in the same cycle.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid_d = 1'b1;
        y_d        = sh_y;
        flags_d    = sh_flags;
      end else if (s2_drain) begin
        s2_valid_d = 1'b0;
      end

      if (accept) begin
        s1_valid_d = 1'b1;
        s1_a_d     = a;
        s1_b_d     = b;
        s1_op_d    = shift_op_e'(opcode);
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_SRL;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: queue-based reference model checked every cycle, plus literal vectors.
module tb_shift_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [3:0]  b;
  logic [1:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic [2:0]  flags;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] y;
    logic [2:0]  f;
    int          age;
  } exp_t;

  exp_t q[$];

  shift_exec_stage #(.width(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result as {y, n, z, c}: shifts done on a double-width word, carry is the bit just past the edge.
  function automatic logic [18:0] ref_op(input logic [15:0] av, input logic [3:0] bv, input logic [1:0] op);
    logic [31:0] w;
    logic [15:0] r;
    logic        c;
    int          sh;
    sh = int'(bv);
    case (op)
      2'b00: begin w = {av, 16'h0000} >> sh; r = w[31:16]; c = w[15]; end
      2'b01: begin w = {16'h0000, av} << sh; r = w[15:0];  c = w[16]; end
      2'b10: begin w = {av, av} >> sh;       r = w[15:0];  c = (sh > 0) && r[15]; end
      default: begin w = {av, av} << sh;     r = w[31:16]; c = (sh > 0) && r[0]; end
    endcase
    return {r, r[15], (r == 16'h0000), c};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ops in flight in acceptance order; the head is visible once it has aged one edge.
  logic ov_m, ir_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      ov_m = (q.size() > 0) && (q[0].age >= 1);
      ir_m = !flush && !((q.size() == 2) && !out_ready);
      if (flush) begin
        q.delete();
      end else begin
        exp_t e;
        logic [18:0] r;
        if (ov_m && out_ready) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (in_valid && ir_m) begin
          r     = ref_op(a, b, opcode);
          e.y   = r[18:3];
          e.f   = r[2:0];
          e.age = 0;
          q.push_back(e);
        end
      end
    end
  end

  logic ov_e, ir_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_y", 32'(y), 32'(0));
      chk("rst_flags", 32'(flags), 32'(0));
    end else begin
      ov_e = (q.size() > 0) && (q[0].age >= 1);
      ir_e = !flush && !((q.size() == 2) && !out_ready);
      chk("out_valid", 32'(out_valid), 32'(ov_e));
      chk("in_ready", 32'(in_ready), 32'(ir_e));
      if (ov_e && out_valid) begin
        $display("out: y=%h flags=%b", y, flags);
        chk("y", 32'(y), 32'(q[0].y));
        chk("flags", 32'(flags), 32'(q[0].f));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] a_i, input logic [3:0] b_i, input logic [1:0] op_i);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    a = a_i;
    b = b_i;
    opcode = op_i;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    $display("send: a=%h b=%0d op=%0d accepted=%0d", a_i, b_i, op_i, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles at %0t", $time);
    end
  endtask

  // Pin the model with a hand-computed {y, n, z, c} before driving the vector.
  task automatic send_chk(input logic [15:0] a_i, input logic [3:0] b_i, input logic [1:0] op_i,
                          input logic [18:0] exp);
    chk("model_literal", 32'(ref_op(a_i, b_i, op_i)), 32'(exp));
    send(a_i, b_i, op_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    opcode = '0;
    out_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    send_chk(16'h8001, 4'd1, 2'b00, {16'h4000, 3'b001});
    idle(3);
    send_chk(16'h8001, 4'd1, 2'b11, {16'h0003, 3'b001});
    send_chk(16'h8001, 4'd1, 2'b10, {16'hC000, 3'b101});
    send_chk(16'h0001, 4'd0, 2'b01, {16'h0001, 3'b000});
    send_chk(16'h0001, 4'd1, 2'b00, {16'h0000, 3'b011});
    send_chk(16'h0001, 4'd15, 2'b01, {16'h8000, 3'b100});
    send_chk(16'h8000, 4'd15, 2'b00, {16'h0001, 3'b000});
    send_chk(16'h1234, 4'd4, 2'b10, {16'h4123, 3'b000});
    idle(4);

    // Four back-to-back ops against a stalled output.
    out_ready = 1'b0;
    fork
      begin
        send(16'hA5A5, 4'd3, 2'b00);
        send(16'h0F0F, 4'd5, 2'b01);
        send(16'hF000, 4'd7, 2'b10);
        send(16'h00FF, 4'd9, 2'b11);
      end
      begin
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Flush with both stages full and a new op offered.
    out_ready = 1'b0;
    send(16'h1111, 4'd1, 2'b01);
    send(16'h2222, 4'd2, 2'b01);
    in_valid = 1'b1;
    a = 16'h3333;
    b = 4'd3;
    opcode = 2'b00;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Random traffic under random backpressure.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(16'($urandom), 4'($urandom), 2'($urandom));
          idle($urandom_range(0, 2));
        end
      end
      begin
        for (int j = 0; j < 150; j++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Asynchronous reset in the middle of a stream.
    fork
      begin
        for (int k = 0; k < 6; k++) send(16'h0100 + 16'(k), 4'(k), 2'(k));
      end
      begin
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'(0));
        chk("async_rst_y", 32'(y), 32'(0));
        chk("async_rst_flags", 32'(flags), 32'(0));
        idle(1);
        rst_n = 1'b1;
      end
    join
    send_chk(16'h8001, 4'd1, 2'b00, {16'h4000, 3'b001});
    send_chk(16'hFFFF, 4'd8, 2'b01, {16'hFF00, 3'b101});
    idle(5);
    chk("drained", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
